// File: rtl/hack_alu_sequencer.sv
// hack_alu_sequencer
//   Control side of the 16-bit Hack ALU. Accepts one Hack instruction at a time
//   over a valid/ready handshake, drives the combinational ALU with operands and
//   the six control bits, captures the result and flags, and then commits that
//   result to A/D/memory and updates the PC. Owns the architectural A, D and PC
//   registers.
//
//   Sequence: IDLE -> EXEC -> IDLE          (A-instruction, 2 cycles)
//             IDLE -> EXEC -> WB -> IDLE    (C-instruction, 3 cycles)
//
// Parameters
//   ADDR_W    data-memory / PC address width (A[ADDR_W-1:0] is the address)
//   PC_RESET  PC value loaded on reset
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   instr_valid/ready      instruction handshake; ready is high only in IDLE
//   instr[15:0]            Hack instruction word
//   alu_x, alu_y           ALU operands (D, and A or M), zero outside EXEC
//   alu_zx..alu_no         ALU control bits, zero outside EXEC
//   alu_out, alu_zr/ng     ALU result and flags, sampled at the end of EXEC
//   m_addr                 data-memory address = A[ADDR_W-1:0]
//   m_rdata                data-memory read data (combinational on m_addr)
//   m_wdata, m_we          data-memory write data and one-cycle strobe (WB)
//   pc, a_reg, d_reg       architectural PC, A and D

module hack_alu_sequencer #(
    parameter int ADDR_W   = 15,
    parameter int PC_RESET = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [15:0]       alu_x,
    output logic [15:0]       alu_y,
    output logic              alu_zx,
    output logic              alu_nx,
    output logic              alu_zy,
    output logic              alu_ny,
    output logic              alu_f,
    output logic              alu_no,
    input  logic [15:0]       alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [ADDR_W-1:0] m_addr,
    input  logic [15:0]       m_rdata,
    output logic [15:0]       m_wdata,
    output logic              m_we,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       a_reg,
    output logic [15:0]       d_reg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t            state;
    logic [15:0]       ir;        // latched instruction
    logic [15:0]       res;       // ALU result captured at end of EXEC
    logic              zr_q;
    logic              ng_q;
    logic [5:0]        ctrl_q;    // zx,nx,zy,ny,f,no
    logic [ADDR_W-1:0] pc_inc;
    logic              c_exec;
    logic              take_jump;

    // ir[14:13] are don't-care bits of a C-instruction.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[14:13];

    assign instr_ready = (state == IDLE);
    assign pc_inc      = pc + ADDR_W'(1);
    assign m_addr      = a_reg[ADDR_W-1:0];
    assign m_wdata     = res;

    // Operands are only presented while a C-instruction is executing; m_rdata
    // comes back combinationally from the address held in A.
    assign c_exec = (state == EXEC) && ir[15];
    assign alu_x  = c_exec ? d_reg : 16'h0000;
    assign alu_y  = c_exec ? (ir[12] ? m_rdata : a_reg) : 16'h0000;

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl_q;

    // j3 (result > 0) is the case where neither flag is set.
    assign take_jump = (ir[2] & ng_q) | (ir[1] & zr_q) | (ir[0] & ~ng_q & ~zr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ir     <= 16'h0000;
            res    <= 16'h0000;
            zr_q   <= 1'b0;
            ng_q   <= 1'b0;
            ctrl_q <= 6'b000000;
            m_we   <= 1'b0;
            a_reg  <= 16'h0000;
            d_reg  <= 16'h0000;
            pc     <= ADDR_W'(PC_RESET);
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir     <= instr;
                        // Controls go live in EXEC only for C-instructions.
                        ctrl_q <= instr[15] ? instr[11:6] : 6'b000000;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    ctrl_q <= 6'b000000;
                    if (!ir[15]) begin
                        a_reg <= ir;
                        pc    <= pc_inc;
                        state <= IDLE;
                    end else begin
                        res   <= alu_out;
                        zr_q  <= alu_zr;
                        ng_q  <= alu_ng;
                        m_we  <= ir[3];
                        state <= WB;
                    end
                end
                WB: begin
                    // All destinations commit together; memory address and
                    // jump target both see A as it was before this write.
                    m_we <= 1'b0;
                    if (ir[5]) a_reg <= res;
                    if (ir[4]) d_reg <= res;
                    pc    <= take_jump ? a_reg[ADDR_W-1:0] : pc_inc;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
